// File: rtl/data_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_if
// Description : Word-access bus between the datapath (requester) and the
//               data-memory responder.
//               req/we/addr/wdata : requester -> responder
//               rdata/ready/err/busy : responder -> requester
// Revision    : 1.0  initial release
// ============================================================================
interface data_mem_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, err, busy
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Responder end of the CPU data-memory port. Accepts one word
//               read/write at a time, waits WAIT_STATES cycles, then strobes
//               ready (with err for rejected accesses). Misaligned and
//               out-of-range addresses are flagged and never touch the RAM.
// Ports       : clk   - clock, rising edge
//               reset - synchronous active-high reset
//               bus   - data_mem_if.slave (req/we/addr/wdata in,
//                       rdata/ready/err/busy out)
// Revision    : 1.0  initial release
// ============================================================================
module data_mem_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000
) (
    input  wire         clk,
    input  wire         reset,
    data_mem_if.slave   bus
);

    // Byte span of the RAM; any offset at or above this is out of range.
    localparam logic [31:0] c_RANGE    = 32'(64'd4 << ADDR_WIDTH);
    localparam logic [3:0]  c_CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam bit          c_NO_WAIT  = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic                    r_we;
    logic                    r_bad;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [31:0]             r_wdata;
    logic [31:0]             r_rdata;
    logic [31:0]             r_mem [0:(1<<ADDR_WIDTH)-1];

    logic [31:0]             w_off_in;
    logic                    w_bad_in;
    logic                    w_accept;
    logic                    w_enter_resp;
    logic                    w_acc_we;
    logic                    w_acc_bad;
    logic [ADDR_WIDTH-1:0]   w_acc_idx;
    logic [31:0]             w_acc_wdata;
    logic                    w_do_mem;

    // Address decode of the incoming request. The subtract wraps, so
    // addresses below BASE_ADDR become huge offsets and fail the range test.
    always_comb begin
        w_off_in = bus.addr - BASE_ADDR;
        w_bad_in = (bus.addr[1:0] != 2'b00) || (w_off_in >= c_RANGE);
        w_accept = (r_state == S_IDLE) && bus.req;

        w_enter_resp = (w_accept && (w_bad_in || c_NO_WAIT)) ||
                       ((r_state == S_WAIT) && (r_cnt == 4'd0));

        // When RESP is entered straight from IDLE the latched copies are not
        // yet loaded, so the live bus fields drive the memory action.
        if (r_state == S_IDLE) begin
            w_acc_we    = bus.we;
            w_acc_bad   = w_bad_in;
            w_acc_idx   = w_off_in[ADDR_WIDTH+1:2];
            w_acc_wdata = bus.wdata;
        end else begin
            w_acc_we    = r_we;
            w_acc_bad   = r_bad;
            w_acc_idx   = r_idx;
            w_acc_wdata = r_wdata;
        end

        w_do_mem = w_enter_resp && !w_acc_bad;
    end

    // RAM array: not reset. Reset on the RESP-entry edge cancels the write.
    always_ff @(posedge clk) begin
        if (w_do_mem && w_acc_we && !reset) begin
            r_mem[w_acc_idx] <= w_acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_bad   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            // Only a good read updates rdata; it holds otherwise.
            if (w_do_mem && !w_acc_we) begin
                r_rdata <= r_mem[w_acc_idx];
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_bad   <= w_bad_in;
                        r_idx   <= w_off_in[ADDR_WIDTH+1:2];
                        r_wdata <= bus.wdata;
                        if (w_bad_in || c_NO_WAIT) begin
                            r_state <= S_RESP;
                        end else begin
                            r_cnt   <= c_CNT_LOAD;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ready = (r_state == S_RESP);
    assign bus.err   = (r_state == S_RESP) && r_bad;
    assign bus.busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed self-checking bench. u_dut2 is built with two wait
//               states, u_dut0 with none; both share clock and reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

    logic clk;
    logic reset;
    int   r_checks;
    int   r_fails;
    int   r_cyc;

    data_mem_if b2 ();
    data_mem_if b0 ();

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2), .BASE_ADDR(32'h1001_0000))
        u_dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .BASE_ADDR(32'h1001_0000))
        u_dut0 (.clk(clk), .reset(reset), .bus(b0.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) r_cyc <= r_cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete access on the selected DUT (z=1 -> zero-wait DUT).
    // lat = clock edges from acceptance to the first sample showing ready.
    task automatic access(input bit z, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic e,
                          output logic [31:0] rd, output logic bsy);
        logic rdy;
        if (z) begin b0.req = 1'b1; b0.we = w; b0.addr = a; b0.wdata = d; end
        else   begin b2.req = 1'b1; b2.we = w; b2.addr = a; b2.wdata = d; end
        @(posedge clk); #1;
        bsy = z ? b0.busy : b2.busy;
        if (z) b0.req = 1'b0; else b2.req = 1'b0;
        lat = 0;
        rdy = z ? b0.ready : b2.ready;
        while (!rdy && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            rdy = z ? b0.ready : b2.ready;
        end
        e  = z ? b0.err   : b2.err;
        rd = z ? b0.rdata : b2.rdata;
        @(posedge clk); #1;
    endtask

    int          lat;
    logic        e;
    logic        bsy;
    logic [31:0] rd;
    int          t [4];
    int          n;
    logic        seen;

    initial begin
        r_checks = 0;
        r_fails  = 0;
        r_cyc    = 0;
        b2.req = 0; b2.we = 0; b2.addr = 0; b2.wdata = 0;
        b0.req = 0; b0.we = 0; b0.addr = 0; b0.wdata = 0;

        // T1 reset
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(b2.ready), 32'd0);
        check("rst_err",   32'(b2.err),   32'd0);
        check("rst_busy",  32'(b2.busy),  32'd0);
        check("rst_rdata", b2.rdata,      32'd0);
        check("rst_rdata0", b0.rdata,     32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // T2 write then read, two wait states
        access(0, 1, 32'h1001_0008, 32'hDEADBEEF, lat, e, rd, bsy);
        check("t2_wr_lat",  32'(lat), 32'd2);
        check("t2_wr_err",  32'(e),   32'd0);
        check("t2_wr_busy", 32'(bsy), 32'd1);
        access(0, 0, 32'h1001_0008, 32'h0, lat, e, rd, bsy);
        check("t2_rd_lat",  32'(lat), 32'd2);
        check("t2_rd_err",  32'(e),   32'd0);
        check("t2_rd_data", rd,       32'hDEADBEEF);
        check("t2_idle",    32'(b2.busy), 32'd0);

        // T3 error paths
        access(0, 0, 32'h1001_0002, 32'h0, lat, e, rd, bsy);
        check("t3_mis_lat",  32'(lat), 32'd0);
        check("t3_mis_err",  32'(e),   32'd1);
        check("t3_mis_data", rd,       32'hDEADBEEF);
        access(0, 1, 32'h1001_0FFC, 32'hCAFEF00D, lat, e, rd, bsy);
        check("t3_last_err", 32'(e),   32'd0);
        access(0, 1, 32'h1001_0000, 32'h11111111, lat, e, rd, bsy);
        access(0, 1, 32'h1001_1000, 32'h12345678, lat, e, rd, bsy);
        check("t3_oor_lat",  32'(lat), 32'd0);
        check("t3_oor_err",  32'(e),   32'd1);
        access(0, 0, 32'h1000_FFFC, 32'h0, lat, e, rd, bsy);
        check("t3_below_err", 32'(e),  32'd1);
        access(0, 0, 32'h1001_0FFC, 32'h0, lat, e, rd, bsy);
        check("t3_last_data", rd,      32'hCAFEF00D);
        check("t3_last_rerr", 32'(e),  32'd0);
        access(0, 0, 32'h1001_0000, 32'h0, lat, e, rd, bsy);
        check("t3_w0_data",  rd,       32'h11111111);

        // T4 back-to-back writes with req held high
        b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'h1001_0000; b2.wdata = 32'hA000_0000;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!b2.ready && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            check("t4_ready_seen", 32'(b2.ready), 32'd1);
            t[i] = r_cyc;
            if (i < 3) begin
                b2.addr  = 32'h1001_0000 + 32'(4 * (i + 1));
                b2.wdata = 32'hA000_0000 + 32'(i + 1);
            end else begin
                b2.req = 1'b0;
            end
            @(posedge clk); #1;
        end
        for (int i = 1; i < 4; i++) check("t4_spacing", 32'(t[i] - t[i-1]), 32'd4);
        for (int i = 0; i < 4; i++) begin
            access(0, 0, 32'h1001_0000 + 32'(4 * i), 32'h0, lat, e, rd, bsy);
            check("t4_readback", rd, 32'hA000_0000 + 32'(i));
        end

        // T5 reset during WAIT suppresses the write and produces no ready
        access(0, 1, 32'h1001_0010, 32'h0, lat, e, rd, bsy);
        b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'h1001_0010; b2.wdata = 32'h55AA55AA;
        @(posedge clk); #1;
        b2.req = 1'b0;
        reset  = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        seen   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen = seen | b2.ready;
            @(posedge clk); #1;
        end
        check("t5_no_ready", 32'(seen), 32'd0);
        access(0, 0, 32'h1001_0010, 32'h0, lat, e, rd, bsy);
        check("t5_wait_rst_data", rd, 32'h0);

        // Reset exactly on the RESP-entry edge
        b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'h1001_0010; b2.wdata = 32'h77777777;
        @(posedge clk); #1;
        b2.req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t5_resp_rst_ready", 32'(b2.ready), 32'd0);
        check("t5_resp_rst_rdata", b2.rdata,      32'd0);
        access(0, 0, 32'h1001_0010, 32'h0, lat, e, rd, bsy);
        check("t5_resp_rst_data", rd, 32'h0);

        // T6 zero wait states
        access(1, 1, 32'h1001_0020, 32'h0BADF00D, lat, e, rd, bsy);
        check("t6_wr_lat", 32'(lat), 32'd0);
        check("t6_wr_err", 32'(e),   32'd0);
        access(1, 0, 32'h1001_0020, 32'h0, lat, e, rd, bsy);
        check("t6_rd_lat",  32'(lat), 32'd0);
        check("t6_rd_data", rd,       32'h0BADF00D);
        access(1, 0, 32'h1001_0021, 32'h0, lat, e, rd, bsy);
        check("t6_mis_err",  32'(e),  32'd1);
        check("t6_mis_data", rd,      32'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_fails);
        $finish;
    end

endmodule
`default_nettype wire
